clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures the period of a slow, divided clock in fast `clk` cycles. It is the receiving end of the team's divided-clock generators (for example, the 100 Hz tick clock). It synchronizes the slow clock into the `clk` domain, emits a one-cycle `tick` on each rising edge, and reports each measured period with a valid strobe. It also checks the period against a tolerance window and flags a stalled slow clock with a timeout.

## Interface
- `CNT_W`, 20, width of the cycle counter and of `period`.
- `TIMEOUT`, 500_000, cycle count with no rising edge that raises `timeout`; must be < 2^CNT_W.
- `EXP_PERIOD`, 400_000, expected period in `clk` cycles.
- `TOL`, 4_000, allowed absolute deviation from `EXP_PERIOD`.
- `FILT_LEN`, 4, glitch-filter length in samples; used only when the filter is compiled in.

Ports (name, direction, width, meaning):
- `clk`, in, 1, system clock; all logic is on the rising edge.
- `rst_n`, in, 1, asynchronous, active-low reset.
- `slow_clk`, in, 1, slow clock under measurement; asynchronous to `clk`.
- `enable`, in, 1, measurement enable; level-sensitive.
- `tick`, out, 1, one-cycle pulse per filtered rising edge of `slow_clk`.
- `period`, out, CNT_W, last measured period; holds its value between updates.
- `period_valid`, out, 1, one-cycle strobe marking a new `period`.
- `period_ok`, out, 1, high when |`period` − `EXP_PERIOD`| ≤ `TOL`; updated together with `period_valid`.
- `timeout`, out, 1, sticky flag: no rising edge seen for `TIMEOUT` cycles.

## Operation
- Input path:
  - Two-flop synchronizer produces `s2`.
  - Optional glitch filter produces the filtered level `f`.
  - A delayed copy `f_d` feeds edge detection; a rising edge is `f & ~f_d`.
  - `tick` is the registered rising-edge detect.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: counter held at 0. Go to ARM when `enable`=1.
  - ARM: waits for the first `tick`. Counter increments every cycle. On `tick`: counter ← 1, go to MEASURE, no `period_valid`.
  - MEASURE: counter increments every cycle. On `tick`: `period` ← counter, `period_valid` ← 1, `period_ok` updated, counter ← 1, stay in MEASURE.
- `period` equals the number of `clk` cycles between two consecutive `tick` pulses.
- Timeout:
  - Triggered in ARM or MEASURE when the counter == `TIMEOUT` and there is no `tick` in the same cycle.
  - Sets `timeout` ← 1, counter ← 0, state ← ARM.
  - `timeout` clears on the next `tick`. That tick only re-arms; it produces no valid.
- `enable`=0 in any state: next state is IDLE, counter ← 0, `timeout` ← 0. `period` and `period_ok` hold; `period_valid` is 0.
- Arithmetic:
  - Counter saturates at 2^CNT_W − 1 and never wraps. It cannot reach saturation when `TIMEOUT` is legal.
  - The tolerance check uses (CNT_W+1)-bit unsigned difference: (`period` ≥ `EXP_PERIOD` ? `period` − `EXP_PERIOD` : `EXP_PERIOD` − `period`) ≤ `TOL`.
- Simultaneous events:
  - `tick` in the same cycle as counter == `TIMEOUT`: the tick wins; the period is reported and no timeout is raised.
  - `enable` falling in the same cycle as a `tick`: `enable` wins; no valid.

## Timing
- Reset values: `tick`=0, `period`=0, `period_valid`=0, `period_ok`=0, `timeout`=0. State = IDLE, counter = 0, synchronizer and filter flops = 0.
- Latency from `slow_clk` to `tick`: `slow_clk` first sampled high at edge k gives `tick` high in the cycle after edge k+2 (3-cycle latency). With the filter compiled in, add `FILT_LEN` cycles.
- `period_valid` and `period_ok` are registered in the same cycle as the `tick` that closes the measurement.
- `timeout` rises in the cycle after the counter reaches `TIMEOUT`.
- Reset asserted mid-measurement: all state clears immediately. After release, two rising edges are needed before the first `period_valid`.

## Configuration
- Macro: `CLK_PERIOD_METER_GLITCH_FILTER_EN`.
- Defined: `f` changes only after `s2` has held the new value for `FILT_LEN` consecutive cycles. Pulses shorter than `FILT_LEN` cycles are ignored.
- Undefined: `f` = `s2`; `FILT_LEN` is unused and adds no latency.

## Test plan
All scenarios use `CNT_W`=8, `TIMEOUT`=100, `EXP_PERIOD`=20, `TOL`=2, `FILT_LEN`=4.
- Reset check: assert `rst_n`=0 with `slow_clk` toggling → every output is 0; after release with `enable`=0, no `tick` is ever issued as measurement, `period_valid` stays 0.
- Nominal period: `enable`=1, `slow_clk` period 20 → first `tick` gives no valid; the second gives `period`=20, `period_valid` for 1 cycle, `period_ok`=1, and this repeats each period.
- Out of range: `slow_clk` period 25 → `period`=25, `period_ok`=0; a later period of 18 → `period_ok`=1.
- Stall: after one edge, hold `slow_clk` low → `timeout`=1 about 100 cycles later with no valid; the next edge clears `timeout` with no valid; the following edge produces a valid period.
- Enable drop: deassert `enable` 10 cycles into a measurement → no `period_valid`, `period` holds its old value. After re-enable, the first valid appears only at the second edge.
- Glitch: a 2-cycle high pulse on `slow_clk` → no `tick` when the macro is defined; exactly one `tick` when it is undefined.

Source files
------------

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Measures the period of a slow, divided clock in cycles of the fast clock.
// The slow clock is synchronized into the clk domain, optionally glitch
// filtered, and edge detected. Each filtered rising edge produces a one-cycle
// tick. Consecutive ticks close a measurement, which is reported on period
// with a one-cycle period_valid strobe and a tolerance verdict on period_ok.
// A slow clock that stops toggling raises the sticky timeout flag.
//
// Compile-time option:
//   CLK_PERIOD_METER_GLITCH_FILTER_EN
//     defined   : the synchronized level must hold FILT_LEN consecutive cycles
//                 before it is accepted (adds FILT_LEN cycles of latency).
//     undefined : no filter; FILT_LEN has no effect.
//
// Parameters:
//   CNT_W      width of the cycle counter and of period
//   TIMEOUT    cycles without a rising edge that raise timeout (< 2**CNT_W)
//   EXP_PERIOD expected period in clk cycles
//   TOL        allowed absolute deviation from EXP_PERIOD
//   FILT_LEN   glitch-filter length in samples
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   slow_clk     in   slow clock under measurement (asynchronous to clk)
//   enable       in   level-sensitive measurement enable
//   tick         out  one-cycle pulse per filtered rising edge of slow_clk
//   period       out  last measured period, held between updates
//   period_valid out  one-cycle strobe marking a new period
//   period_ok    out  |period - EXP_PERIOD| <= TOL, updated with period_valid
//   timeout      out  sticky: no rising edge seen for TIMEOUT cycles
// -----------------------------------------------------------------------------
module clk_period_meter #(
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned TIMEOUT    = 500_000,
    parameter int unsigned EXP_PERIOD = 400_000,
    parameter int unsigned TOL        = 4_000,
    parameter int unsigned FILT_LEN   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic             enable,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             period_ok,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   EXP_C     = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    // -------------------------------------------------------------------------
    // Input path: synchronizer, optional filter, edge detect
    // -------------------------------------------------------------------------
    logic s1_q;
    logic s2_q;
    logic f;
    logic f_d_q;
    logic tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= slow_clk;
            s2_q <= s1_q;
        end
    end

`ifdef CLK_PERIOD_METER_GLITCH_FILTER_EN
    // A filter length of 0 behaves like 1 (accept after a single sample).
    localparam int unsigned FLEN   = (FILT_LEN == 0) ? 1 : FILT_LEN;
    localparam int unsigned FC_W   = (FLEN > 1) ? $clog2(FLEN) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLEN - 1);

    logic            filt_q;
    logic            filt_d;
    logic [FC_W-1:0] fcnt_q;
    logic [FC_W-1:0] fcnt_d;

    // fcnt counts how many consecutive cycles s2 has disagreed with the
    // accepted level; any return to agreement restarts the count.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (s2_q != filt_q) begin
            if (fcnt_q == FC_LAST) begin
                filt_d = s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign f = filt_q;
`else
    assign f = s2_q;

    // FILT_LEN only shapes the filter; this build has none.
    if (FILT_LEN == 0) begin : g_no_filter
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_d_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            f_d_q  <= f;
            tick_q <= f & ~f_d_q;
        end
    end

    // -------------------------------------------------------------------------
    // Measurement FSM
    // -------------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic             valid_q;
    logic             valid_d;
    logic             ok_q;
    logic             ok_d;
    logic             timeout_q;
    logic             timeout_d;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   dev;
    logic             in_tol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            ok_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            ok_q      <= ok_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        ok_d      = ok_q;
        timeout_d = timeout_q;

        // Saturating increment; unreachable with a legal TIMEOUT.
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        // Tolerance on the value being latched into period this cycle.
        cnt_ext = {1'b0, cnt_q};
        dev     = (cnt_ext >= EXP_C) ? (cnt_ext - EXP_C) : (EXP_C - cnt_ext);
        in_tol  = (dev <= TOL_C);

        // Priority: enable low, then tick, then timeout, then count.
        if (!enable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (tick_q) begin
                        cnt_d     = CNT_W'(1);
                        timeout_d = 1'b0;
                        state_d   = MEASURE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                MEASURE: begin
                    if (tick_q) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        ok_d     = in_tol;
                        cnt_d    = CNT_W'(1);
                    end else if (cnt_q == TIMEOUT_C) begin
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign tick         = tick_q;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign period_ok    = ok_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
module tb_clk_period_meter;

    localparam int CNT_W      = 8;
    localparam int TIMEOUT    = 100;
    localparam int EXP_PERIOD = 20;
    localparam int TOL        = 2;
    localparam int FILT_LEN   = 4;

`ifdef CLK_PERIOD_METER_GLITCH_FILTER_EN
    localparam int LAT_EXTRA     = FILT_LEN;
    localparam int GLITCH_TICKS  = 0;
`else
    localparam int LAT_EXTRA     = 0;
    localparam int GLITCH_TICKS  = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             slow_clk = 1'b0;
    logic             enable = 1'b0;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             period_ok;
    logic             timeout;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;

    typedef struct packed {
        logic [CNT_W-1:0] p;
        logic             ok;
    } exp_t;

    exp_t sb_q[$];
    int   seq_len[$];
    bit   seq_ok[$];

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .FILT_LEN   (FILT_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .slow_clk     (slow_clk),
        .enable       (enable),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .period_ok    (period_ok),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Advance n cycles, sampling on the falling edge; every period_valid is
    // popped from the scoreboard and compared against the expected entry.
    task automatic cyc(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            if (tick === 1'b1) tick_cnt++;
            if (rst_n === 1'b1 && period_valid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: period_valid=1 period=%0d, required no valid", period);
                end else begin
                    e = sb_q.pop_front();
                    if (period !== e.p || period_ok !== e.ok) begin
                        errors++;
                        $display("FAIL period_report: period=%0d ok=%b, required period=%0d ok=%b",
                                 period, period_ok, e.p, e.ok);
                    end
                end
            end
        end
    endtask

    // One slow clock cycle of p clk cycles, rising edge first.
    task automatic slow_cycle(input int p);
        slow_clk = 1'b1;
        cyc(p / 2);
        slow_clk = 1'b0;
        cyc(p - p / 2);
    endtask

    // Drive seq_len back to back; the edge closing cycle i reports seq_len[i].
    task automatic run_seq();
        exp_t e;
        slow_cycle(seq_len[0]);
        for (int i = 1; i < seq_len.size(); i++) begin
            e.p  = CNT_W'(seq_len[i-1]);
            e.ok = seq_ok[i-1];
            sb_q.push_back(e);
            slow_cycle(seq_len[i]);
        end
    endtask

    task automatic apply_reset();
        slow_clk = 1'b0;
        enable   = 1'b0;
        rst_n    = 1'b0;
        cyc(3);
        sb_q.delete();
        rst_n = 1'b1;
        cyc(3);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            slow_clk = ~slow_clk;
            cyc(1);
            checks++;
            if ({tick, period, period_valid, period_ok, timeout} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: tick=%b period=%0d valid=%b ok=%b timeout=%b, required all 0",
                         tick, period, period_valid, period_ok, timeout);
            end
        end
        slow_clk = 1'b0;
        enable   = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        for (int i = 0; i < 3; i++) slow_cycle(20);
        checks++;
        if (period !== '0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL disabled_idle: period=%0d timeout=%b, required period=0 timeout=0", period, timeout);
        end

        // Reset in the middle of a measurement.
        enable = 1'b1;
        cyc(2);
        slow_cycle(20);
        e.p = 8'd20; e.ok = 1'b1;
        sb_q.push_back(e);
        slow_cycle(20);
        cyc(5);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tick, period, period_valid, period_ok, timeout} !== '0) begin
            errors++;
            $display("FAIL async_reset: tick=%b period=%0d valid=%b ok=%b timeout=%b, required all 0",
                     tick, period, period_valid, period_ok, timeout);
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        slow_cycle(20);
        e.p = 8'd20; e.ok = 1'b1;
        sb_q.push_back(e);
        slow_cycle(20);
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_rearm_drain: pending=%0d, required 0", sb_q.size());
        end
    endtask

    task automatic test_nominal();
        apply_reset();
        enable = 1'b1;
        seq_len = '{20, 20, 20, 20, 20};
        seq_ok  = '{1, 1, 1, 1};
        run_seq();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL nominal_drain: pending=%0d, required 0", sb_q.size());
        end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        enable = 1'b1;
        // 18 and 22 sit on the tolerance edges; 17 and 23 are just outside.
        seq_len = '{25, 25, 18, 22, 23, 17, 20};
        seq_ok  = '{0, 0, 1, 1, 0, 0};
        run_seq();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL range_drain: pending=%0d, required 0", sb_q.size());
        end
    endtask

    task automatic test_timeout_boundary();
        apply_reset();
        enable = 1'b1;
        // A period of exactly TIMEOUT: the tick arrives with counter == TIMEOUT.
        seq_len = '{100, 100};
        seq_ok  = '{0};
        run_seq();
        checks++;
        if (sb_q.size() !== 0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL tick_wins: pending=%0d timeout=%b, required pending=0 timeout=0", sb_q.size(), timeout);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   found;
        apply_reset();
        enable = 1'b1;
        cyc(2);
        slow_clk = 1'b1;
        found = 0;
        for (int i = 1; i <= 200 && found == 0; i++) begin
            cyc(1);
            if (i == 10) slow_clk = 1'b0;
            if (timeout === 1'b1) found = i;
        end
        checks++;
        if (found != 104 + LAT_EXTRA) begin
            errors++;
            $display("FAIL timeout_latency: rose at cycle %0d, required %0d", found, 104 + LAT_EXTRA);
        end
        cyc(5);
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: timeout=%b, required 1", timeout);
        end
        slow_cycle(20);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: timeout=%b, required 0", timeout);
        end
        e.p = 8'd20; e.ok = 1'b1;
        sb_q.push_back(e);
        slow_cycle(20);
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL stall_recover: pending=%0d, required 0", sb_q.size());
        end
    endtask

    task automatic test_enable_drop();
        exp_t e;
        apply_reset();
        enable = 1'b1;
        cyc(2);
        slow_cycle(20);
        e.p = 8'd20; e.ok = 1'b1;
        sb_q.push_back(e);
        slow_cycle(20);
        sb_q.push_back(e);
        slow_clk = 1'b1;
        cyc(10);
        enable   = 1'b0;
        slow_clk = 1'b0;
        cyc(10);
        slow_cycle(20);
        slow_cycle(20);
        checks++;
        if (sb_q.size() !== 0 || period !== 8'd20 || period_ok !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL enable_hold: pending=%0d period=%0d ok=%b timeout=%b, required 0/20/1/0",
                     sb_q.size(), period, period_ok, timeout);
        end
        enable = 1'b1;
        cyc(2);
        slow_cycle(19);
        e.p = 8'd19; e.ok = 1'b1;
        sb_q.push_back(e);
        slow_cycle(21);
        checks++;
        if (sb_q.size() !== 0 || period !== 8'd19) begin
            errors++;
            $display("FAIL reenable: pending=%0d period=%0d, required 0/19", sb_q.size(), period);
        end
    endtask

    task automatic test_glitch();
        int t0;
        apply_reset();
        enable = 1'b1;
        cyc(2);
        t0 = tick_cnt;
        slow_clk = 1'b1;
        cyc(2);
        slow_clk = 1'b0;
        cyc(20);
        checks++;
        if (tick_cnt - t0 !== GLITCH_TICKS) begin
            errors++;
            $display("FAIL glitch_ticks: ticks=%0d, required %0d", tick_cnt - t0, GLITCH_TICKS);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_out_of_range();
        test_timeout_boundary();
        test_stall();
        test_enable_drop();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
